move_sequencer: RTL and testbench

Game-flow controller in front of the 3x3 grid update block. Converts level button inputs into single-cycle, mutually exclusive move pulses. Paces moves so each grid update and tile spawn settles before the next move is accepted, and issues new-game resets to the update block. Tracks game-over (and optionally win) state and keeps a saturating move counter for the display path.

---
 rtl/game_pkg.sv | 41 ++++
 rtl/move_sequencer_btn_arbiter.sv | 32 +++
 rtl/move_sequencer.sv | 170 +++++++++++++++++
 tb/tb_move_sequencer.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the 3x3 game flow logic.
//   - FSM state codes (INIT..WIN) and the matching enum type
//   - grid geometry (GRID_W, TILE_W, N_TILES)
//   - direction bit positions used by the one-hot direction vector
//   - tile_at(): extracts tile idx from a packed grid
package game_pkg;

  localparam int GRID_W  = 27;
  localparam int TILE_W  = 3;
  localparam int N_TILES = 9;

  localparam logic [2:0] INIT   = 3'd0;
  localparam logic [2:0] IDLE   = 3'd1;
  localparam logic [2:0] ARMED  = 3'd2;
  localparam logic [2:0] MOVE   = 3'd3;
  localparam logic [2:0] SETTLE = 3'd4;
  localparam logic [2:0] OVER   = 3'd5;
  localparam logic [2:0] WIN    = 3'd6;

  typedef enum logic [2:0] {
    ST_INIT   = INIT,
    ST_IDLE   = IDLE,
    ST_ARMED  = ARMED,
    ST_MOVE   = MOVE,
    ST_SETTLE = SETTLE,
    ST_OVER   = OVER,
    ST_WIN    = WIN
  } state_e;

  // Bit positions inside the one-hot direction vector {d, u, l, r}.
  localparam int DIR_R = 0;
  localparam int DIR_L = 1;
  localparam int DIR_U = 2;
  localparam int DIR_D = 3;

  function automatic logic [TILE_W-1:0] tile_at(input logic [GRID_W-1:0] g,
                                                input int idx);
    return g[idx*TILE_W +: TILE_W];
  endfunction

endpackage

// File: rtl/move_sequencer_btn_arbiter.sv
// btn_arbiter: purely combinational decode of the four direction buttons.
// Ports:
//   btn_r/l/u/d : level direction buttons
//   dir_any     : any direction pressed
//   dir_one     : exactly one direction pressed
//   dir_oh      : one-hot {d,u,l,r} of the pressed direction, zero unless dir_one
module btn_arbiter
  import game_pkg::*;
(
  input  logic       btn_r,
  input  logic       btn_l,
  input  logic       btn_u,
  input  logic       btn_d,
  output logic       dir_any,
  output logic       dir_one,
  output logic [3:0] dir_oh
);

  logic [3:0] btns;

  always_comb begin
    btns         = '0;
    btns[DIR_R]  = btn_r;
    btns[DIR_L]  = btn_l;
    btns[DIR_U]  = btn_u;
    btns[DIR_D]  = btn_d;
    dir_any      = |btns;
    dir_one      = $onehot(btns);
    dir_oh       = dir_one ? btns : 4'b0000;
  end

endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: game-flow controller in front of the 3x3 grid update block.
// Turns level buttons into single-cycle, mutually exclusive move pulses, paces
// moves so each update/spawn settles, issues new-game resets and tracks
// game-over state plus a saturating move counter.
//
// Optional feature: define MOVE_SEQ_WIN_EN to compile in win detection
// (any tile == WIN_TILE) and make the WIN state reachable.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   btn_r/l/u/d, btn_new     : level buttons (already synchronized/debounced)
//   grid[26:0], lose         : status from the update block
//   move_r/l/u/d             : one-cycle move pulses, at most one high
//   game_rst                 : one-cycle reset pulse to the update block
//   state[2:0]               : FSM state code
//   busy                     : high in MOVE and SETTLE
//   move_count               : moves issued this game, saturating
//
// state  | meaning
// INIT   | pulse game_rst, clear move counter
// IDLE   | wait for all buttons released
// ARMED  | accept a single direction or a new-game request
// MOVE   | emit latched move pulse, count it
// SETTLE | let the grid update and spawn settle, then sample lose/win
// OVER   | lost; only btn_new is honoured
// WIN    | won (MOVE_SEQ_WIN_EN only); only btn_new is honoured
module move_sequencer
  import game_pkg::*;
#(
  parameter int         HOLD_CYCLES = 4,
  parameter int         MOVE_CNT_W  = 16,
  parameter logic [2:0] WIN_TILE    = 3'd7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_r,
  input  logic                  btn_l,
  input  logic                  btn_u,
  input  logic                  btn_d,
  input  logic                  btn_new,
  input  logic [GRID_W-1:0]     grid,
  input  logic                  lose,
  output logic                  move_r,
  output logic                  move_l,
  output logic                  move_u,
  output logic                  move_d,
  output logic                  game_rst,
  output logic [2:0]            state,
  output logic                  busy,
  output logic [MOVE_CNT_W-1:0] move_count
);

  localparam logic [7:0] SETTLE_LOAD = 8'(HOLD_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            dir_q, dir_d;
  logic [7:0]            settle_q, settle_d;
  logic [MOVE_CNT_W-1:0] cnt_q, cnt_d;

  logic       dir_any, dir_one;
  logic [3:0] dir_oh;
  logic       win_hit;

  btn_arbiter u_arb (
    .btn_r   (btn_r),
    .btn_l   (btn_l),
    .btn_u   (btn_u),
    .btn_d   (btn_d),
    .dir_any (dir_any),
    .dir_one (dir_one),
    .dir_oh  (dir_oh)
  );

`ifdef MOVE_SEQ_WIN_EN
  always_comb begin
    win_hit = 1'b0;
    for (int i = 0; i < N_TILES; i++) begin
      if (tile_at(grid, i) == WIN_TILE) win_hit = 1'b1;
    end
  end
`else
  logic unused_win;
  assign win_hit    = 1'b0;
  assign unused_win = ^{grid, WIN_TILE};
`endif

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!dir_any && !btn_new) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // The counter is cleared on entry to INIT so move_count already
        // reads zero while game_rst is pulsing.
        if (btn_new) begin
          cnt_d   = '0;
          state_d = ST_INIT;
        end else if (dir_one) begin
          dir_d   = dir_oh;
          state_d = ST_MOVE;
        end else if (dir_any) begin
          state_d = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
        settle_d = SETTLE_LOAD;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == 8'd0) begin
          if (lose)         state_d = ST_OVER;
          else if (win_hit) state_d = ST_WIN;
          else              state_d = ST_IDLE;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      ST_OVER: begin
        if (btn_new) begin
          cnt_d   = '0;
          state_d = ST_INIT;
        end
      end
`ifdef MOVE_SEQ_WIN_EN
      ST_WIN: begin
        if (btn_new) begin
          cnt_d   = '0;
          state_d = ST_INIT;
        end
      end
`endif
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs are gated by rst so a reset in the middle of a move can never
  // leak a pulse before the registers clear at the next edge.
  always_comb begin
    {move_d, move_u, move_l, move_r} = 4'b0000;
    if (!rst && state_q == ST_MOVE) {move_d, move_u, move_l, move_r} = dir_q;
    game_rst   = !rst && (state_q == ST_INIT);
    busy       = !rst && (state_q == ST_MOVE || state_q == ST_SETTLE);
    state      = rst ? INIT : state_q;
    move_count = rst ? '0 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      dir_q    <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
module tb_move_sequencer;

  localparam int HOLD = 4;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_r = 1'b0, btn_l = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic          btn_new = 1'b0;
  logic [26:0]   grid = '0;
  logic          lose = 1'b0;
  logic          move_r, move_l, move_u, move_d;
  logic          game_rst;
  logic [2:0]    state;
  logic          busy;
  logic [CW-1:0] move_count;
  logic [3:0]    mv;

  assign mv = {move_d, move_u, move_l, move_r};

  move_sequencer #(.HOLD_CYCLES(HOLD), .MOVE_CNT_W(CW), .WIN_TILE(3'd7)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_r      (btn_r),
    .btn_l      (btn_l),
    .btn_u      (btn_u),
    .btn_d      (btn_d),
    .btn_new    (btn_new),
    .grid       (grid),
    .lose       (lose),
    .move_r     (move_r),
    .move_l     (move_l),
    .move_u     (move_u),
    .move_d     (move_d),
    .game_rst   (game_rst),
    .state      (state),
    .busy       (busy),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_pulses [4];
  int exp_pulses [4];
  logic [CW-1:0] exp_count;

  // Reference model helpers: game-level bookkeeping only.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Pulse scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    n_checks++;
    if ($countones(mv) > 1) begin
      n_fail++;
      $display("FAIL move_exclusive: got %b, required at most one bit", mv);
    end
    for (int i = 0; i < 4; i++) if (mv[i]) obs_pulses[i]++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_d, btn_u, btn_l, btn_r} = b;
  endtask

  task automatic wait_armed(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (state == 3'd2) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_btn(4'b0000);
    btn_new = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b0 || game_rst !== 1'b0 || mv !== 4'b0 || move_count !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got state=%0d busy=%b grst=%b mv=%b cnt=%0d, required 0/0/0/0000/0",
               state, busy, game_rst, mv, move_count);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (game_rst !== 1'b1 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release_grst: got grst=%b state=%0d, required 1/0", game_rst, state);
    end
    cyc();
    n_checks++;
    if (game_rst !== 1'b0 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_then_idle: got grst=%b state=%0d, required 0/1", game_rst, state);
    end
    cyc();
    n_checks++;
    if (state !== 3'd2 || move_count !== '0) begin
      n_fail++;
      $display("FAIL reset_then_armed: got state=%0d cnt=%0d, required 2/0", state, move_count);
    end
    exp_count = '0;
  endtask

  task automatic test_hold_repeat();
    bit ok;
    int pulses, busy_n;
    pulses = 0;
    busy_n = 0;
    wait_armed(ok);
    btn_r = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 0) begin
        n_checks++;
        if (move_r !== 1'b1) begin
          n_fail++;
          $display("FAIL hold_latency: got move_r=%b, required 1", move_r);
        end
      end
      if (move_r === 1'b1) pulses++;
      if (busy === 1'b1) busy_n++;
    end
    exp_pulses[0]++;
    exp_count = sat_inc(exp_count);
    n_checks++;
    if (pulses != 1 || busy_n != HOLD + 1) begin
      n_fail++;
      $display("FAIL hold_single_pulse: got pulses=%0d busy=%0d, required 1/%0d", pulses, busy_n, HOLD + 1);
    end
    n_checks++;
    if (state !== 3'd1 || move_count !== exp_count) begin
      n_fail++;
      $display("FAIL hold_idle_count: got state=%0d cnt=%0d, required 1/%0d", state, move_count, exp_count);
    end
    btn_r = 1'b0;
    cyc();
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++;
      $display("FAIL release_arms: got state=%0d, required 2", state);
    end
    btn_r = 1'b1;
    cyc();
    btn_r = 1'b0;
    n_checks++;
    if (move_r !== 1'b1) begin
      n_fail++;
      $display("FAIL second_press: got move_r=%b, required 1", move_r);
    end
    exp_pulses[0]++;
    exp_count = sat_inc(exp_count);
    cyc();
    n_checks++;
    if (move_count !== exp_count) begin
      n_fail++;
      $display("FAIL second_count: got %0d, required %0d", move_count, exp_count);
    end
    wait_armed(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hold_rearm_timeout: got state=%0d, required 2", state);
    end
  endtask

  task automatic test_multi();
    bit ok;
    wait_armed(ok);
    set_btn(4'b0110);
    cyc();
    n_checks++;
    if (state !== 3'd1 || mv !== 4'b0) begin
      n_fail++;
      $display("FAIL multi_reject: got state=%0d mv=%b, required 1/0000", state, mv);
    end
    repeat (4) cyc();
    btn_l = 1'b0;
    cyc();
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL multi_partial_release: got state=%0d, required 1", state);
    end
    btn_u = 1'b0;
    cyc();
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++;
      $display("FAIL multi_full_release: got state=%0d, required 2", state);
    end
  endtask

  task automatic test_lose_early();
    bit ok;
    wait_armed(ok);
    btn_l = 1'b1;
    cyc();
    btn_l = 1'b0;
    exp_pulses[1]++;
    exp_count = sat_inc(exp_count);
    cyc();
    lose = 1'b1;
    repeat (HOLD - 1) cyc();
    lose = 1'b0;
    cyc();
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++;
      $display("FAIL lose_early_ignored: got state=%0d, required 1", state);
    end
  endtask

  task automatic test_lose_over();
    bit ok;
    wait_armed(ok);
    btn_d = 1'b1;
    cyc();
    btn_d = 1'b0;
    n_checks++;
    if (move_d !== 1'b1) begin
      n_fail++;
      $display("FAIL lose_move_d: got %b, required 1", move_d);
    end
    exp_pulses[3]++;
    exp_count = sat_inc(exp_count);
    repeat (HOLD) cyc();
    n_checks++;
    if (state !== 3'd4 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lose_last_settle: got state=%0d busy=%b, required 4/1", state, busy);
    end
    lose = 1'b1;
    cyc();
    lose = 1'b0;
    n_checks++;
    if (state !== 3'd5 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lose_over: got state=%0d busy=%b, required 5/0", state, busy);
    end
    btn_d = 1'b1;
    repeat (3) cyc();
    btn_d = 1'b0;
    n_checks++;
    if (state !== 3'd5 || move_count !== exp_count) begin
      n_fail++;
      $display("FAIL over_ignores_dir: got state=%0d cnt=%0d, required 5/%0d", state, move_count, exp_count);
    end
    btn_new = 1'b1;
    cyc();
    btn_new = 1'b0;
    exp_count = '0;
    n_checks++;
    if (state !== 3'd0 || game_rst !== 1'b1 || move_count !== exp_count) begin
      n_fail++;
      $display("FAIL over_new_game: got state=%0d grst=%b cnt=%0d, required 0/1/0", state, game_rst, move_count);
    end
    cyc();
    n_checks++;
    if (state !== 3'd1 || game_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL new_game_idle: got state=%0d grst=%b, required 1/0", state, game_rst);
    end
  endtask

  task automatic test_new_priority();
    bit ok;
    wait_armed(ok);
    btn_new = 1'b1;
    btn_r   = 1'b1;
    cyc();
    n_checks++;
    if (state !== 3'd0 || game_rst !== 1'b1 || mv !== 4'b0) begin
      n_fail++;
      $display("FAIL new_beats_dir: got state=%0d grst=%b mv=%b, required 0/1/0000", state, game_rst, mv);
    end
    btn_new = 1'b0;
    btn_r   = 1'b0;
    exp_count = '0;
    cyc();
    cyc();
    n_checks++;
    if (state !== 3'd2 || move_count !== exp_count) begin
      n_fail++;
      $display("FAIL new_then_armed: got state=%0d cnt=%0d, required 2/0", state, move_count);
    end
  endtask

  task automatic test_win();
    bit ok;
    logic [2:0] exp_st;
    for (int k = 0; k < 2; k++) begin
      wait_armed(ok);
      btn_l = 1'b1;
      cyc();
      btn_l = 1'b0;
      exp_pulses[1]++;
      exp_count = sat_inc(exp_count);
      repeat (HOLD) cyc();
      grid[14:12] = 3'd7;
      lose = (k == 1);
`ifdef MOVE_SEQ_WIN_EN
      exp_st = (k == 1) ? 3'd5 : 3'd6;
`else
      exp_st = (k == 1) ? 3'd5 : 3'd1;
`endif
      cyc();
      n_checks++;
      if (state !== exp_st) begin
        n_fail++;
        $display("FAIL win_tile_k%0d: got state=%0d, required %0d", k, state, exp_st);
      end
      grid = '0;
      lose = 1'b0;
      if (exp_st != 3'd1) begin
        btn_new = 1'b1;
        cyc();
        btn_new = 1'b0;
        exp_count = '0;
      end
    end
  endtask

  task automatic test_rst_abort();
    bit ok;
    wait_armed(ok);
    btn_u = 1'b1;
    cyc();
    btn_u = 1'b0;
    n_checks++;
    if (move_u !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_move_u: got %b, required 1", move_u);
    end
    exp_pulses[2]++;
    cyc();
    rst = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b0 || game_rst !== 1'b0 || mv !== 4'b0 || move_count !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got state=%0d busy=%b grst=%b mv=%b cnt=%0d, required 0/0/0/0000/0",
               state, busy, game_rst, mv, move_count);
    end
    repeat (HOLD + 2) cyc();
    n_checks++;
    if (state !== 3'd0 || busy !== 1'b0 || move_count !== '0) begin
      n_fail++;
      $display("FAIL abort_held: got state=%0d busy=%b cnt=%0d, required 0/0/0", state, busy, move_count);
    end
    rst = 1'b0;
    exp_count = '0;
    #1;
    n_checks++;
    if (game_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_release_grst: got %b, required 1", game_rst);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [3:0] pat, exp_mv;
    bit newb;
    int hold;
    for (int ep = 0; ep < 40; ep++) begin
      wait_armed(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_arm_timeout ep%0d: got state=%0d, required 2", ep, state);
      end
      pat  = 4'($urandom_range(1, 15));
      newb = ($urandom_range(0, 7) == 0);
      hold = $urandom_range(1, 6);
      set_btn(pat);
      btn_new = newb;
      exp_mv = (newb || $countones(pat) != 1) ? 4'b0 : pat;
      cyc();
      n_checks++;
      if (mv !== exp_mv || game_rst !== newb) begin
        n_fail++;
        $display("FAIL rand_pulse ep%0d: got mv=%b grst=%b, required %b/%b", ep, mv, game_rst, exp_mv, newb);
      end
      if (newb) exp_count = '0;
      else if (exp_mv != 4'b0) begin
        exp_count = sat_inc(exp_count);
        for (int i = 0; i < 4; i++) if (exp_mv[i]) exp_pulses[i]++;
      end
      repeat (hold - 1) cyc();
      set_btn(4'b0000);
      btn_new = 1'b0;
      repeat (HOLD + 2) cyc();
      n_checks++;
      if (move_count !== exp_count) begin
        n_fail++;
        $display("FAIL rand_count ep%0d: got %0d, required %0d", ep, move_count, exp_count);
      end
    end
  endtask

  task automatic test_pulse_totals();
    repeat (2) cyc();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_pulses[i] != exp_pulses[i]) begin
        n_fail++;
        $display("FAIL pulse_total dir%0d: got %0d, required %0d", i, obs_pulses[i], exp_pulses[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      obs_pulses[i] = 0;
      exp_pulses[i] = 0;
    end
    exp_count = '0;
    test_reset();
    test_hold_repeat();
    test_multi();
    test_lose_early();
    test_lose_over();
    test_new_priority();
    test_win();
    test_rst_abort();
    test_random();
    test_pulse_totals();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
